// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pipelined imem requests, in-order response queue, redirect flush
// Optional FETCH_BYPASS_EN forwards a response straight to id_* when the queue is empty.
module fetch_unit #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_inst,
    output logic [AW-1:0] id_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
    state_t state_q, state_d;

    logic [AW-1:0] pc_q;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q;
    logic [PW-1:0] tq_wr, tq_rd, iq_wr, iq_rd;
    logic [AW-1:0] tq_pc [DEPTH];
    logic [DW-1:0] iq_data [DEPTH];
    logic [AW-1:0] iq_pc [DEPTH];

    logic          rsp_fire, req_fire, q_empty, bypass, push, pop, credit_ok;
    logic [AW-1:0] tag_pc;

    // Queued plus in-flight instructions never exceed DEPTH, so a response always finds room.
    assign rsp_fire       = imem_rsp_valid && (out_q != '0);
    assign tag_pc         = tq_pc[tq_rd];
    assign q_empty        = (cnt_q == '0);
    assign credit_ok      = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = (state_q != IDLE) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef FETCH_BYPASS_EN
    assign bypass = q_empty && (disc_q == '0) && !redirect_valid && rsp_fire;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid = !q_empty || bypass;
    assign id_inst  = bypass ? imem_rsp_data : (q_empty ? '0 : iq_data[iq_rd]);
    assign id_pc    = bypass ? tag_pc : (q_empty ? '0 : iq_pc[iq_rd]);

    assign push  = rsp_fire && (disc_q == '0) && !redirect_valid && !(bypass && id_ready);
    assign pop   = !q_empty && id_ready && !redirect_valid;
    assign out_d = out_q + CW'(req_fire) - CW'(rsp_fire);

    always_comb begin
        state_d = state_q;
        disc_d  = disc_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH, FLUSH: begin
                // On redirect every request still in flight becomes stale, minus the one answered now.
                if (redirect_valid)
                    disc_d = out_q - CW'(rsp_fire);
                else if (rsp_fire && (disc_q != '0))
                    disc_d = disc_q - CW'(1);
                state_d = (disc_d != '0) ? FLUSH : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            tq_wr   <= '0;
            tq_rd   <= '0;
            iq_wr   <= '0;
            iq_rd   <= '0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
            out_q   <= out_d;
            if (redirect_valid)
                pc_q <= redirect_pc;
            else if (req_fire)
                pc_q <= pc_q + AW'(1);
            if (req_fire)
                tq_wr <= tq_wr + PW'(1);
            if (rsp_fire)
                tq_rd <= tq_rd + PW'(1);
            if (redirect_valid) begin
                iq_wr <= '0;
                iq_rd <= '0;
                cnt_q <= '0;
            end else begin
                if (push)
                    iq_wr <= iq_wr + PW'(1);
                if (pop)
                    iq_rd <= iq_rd + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: the pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (req_fire)
            tq_pc[tq_wr] <= pc_q;
        if (push) begin
            iq_data[iq_wr] <= imem_rsp_data;
            iq_pc[iq_wr]   <= tag_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a fetch-stream reference model
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_inst, id_pc;

    fetch_unit #(.AW(32), .DW(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    // Memory model: in-order pipeline of accepted requests, each tagged with the fetch epoch it belongs to.
    int          mem_due[$];
    logic [31:0] mem_addr[$];
    int          mem_ep[$];
    int lat_min = 1, lat_max = 1;
    // Fetch-stream model: consumed instructions must be contiguous from the last target.
    int          epoch = 0, live = 0, consumed = 0;
    logic [31:0] exp_req, exp_pc, last_req;
    bit          last_req_ok, saw_wrap, expect_vis, expect_empty;
    bit          stall_arm, stall_hit, collide_arm, collide_seen;
    logic [31:0] stall_pc, collide_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    task automatic model_reset();
        mem_due.delete();
        mem_addr.delete();
        mem_ep.delete();
        epoch++;
        live = 0;
        consumed = 0;
        exp_req = RESET_PC;
        exp_pc = RESET_PC;
        last_req_ok = 0;
        expect_vis = 0;
        expect_empty = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    // One clock cycle: drive memory/downstream inputs, check outputs against the model, advance.
    task automatic step(input logic rdy, input logic rr, input logic redir_in, input logic [31:0] rpc);
        bit          rsp_now, redir, took, fresh, fired;
        logic [31:0] rsp_a, took_pc, rpc_eff;
        int          rsp_ep, stale, due;
        rsp_now = (mem_due.size() > 0) && (mem_due[0] == cyc);
        rsp_a = '0;
        rsp_ep = -1;
        took_pc = '0;
        if (rsp_now) begin
            rsp_a = mem_addr.pop_front();
            rsp_ep = mem_ep.pop_front();
            void'(mem_due.pop_front());
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data = rsp_now ? word_of(rsp_a) : $urandom;
        id_ready = rdy;
        imem_req_ready = rr;
        redir = redir_in;
        rpc_eff = rpc;
        redirect_valid = redir;
        redirect_pc = rpc;
        fired = 0;
        #2;
        if (stall_arm && id_valid === 1'b1 && id_pc === stall_pc) begin
            stall_arm = 0;
            stall_hit = 1;
            id_ready = 1'b0;
        end
        if (collide_arm && !redir && rsp_now && id_valid === 1'b1 && id_ready === 1'b1) begin
            redir = 1;
            fired = 1;
            rpc_eff = collide_pc;
            redirect_valid = 1'b1;
            redirect_pc = collide_pc;
        end
        #1;
        if (fired && id_valid === 1'b1) begin
            collide_seen = 1;
            collide_arm = 0;
        end
        if (expect_empty) begin
            checks++;
            if (id_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty: id_valid=%b required 0 (cycle %0d)", id_valid, cyc);
            end
        end
        if (expect_vis) begin
            checks++;
            if (id_valid !== 1'b1) begin
                errors++;
                $display("FAIL rsp_latency: id_valid=%b required 1 one cycle after response (cycle %0d)", id_valid, cyc);
            end
        end
        expect_vis = 0;
        expect_empty = 0;
        if (redir) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_in_redirect: imem_req_valid=%b required 0 (cycle %0d)", imem_req_valid, cyc);
            end
        end
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            checks++;
            if (imem_req_addr !== exp_req) begin
                errors++;
                $display("FAIL req_addr: got %h required %h (cycle %0d)", imem_req_addr, exp_req, cyc);
            end
            if (last_req_ok && last_req == 32'hFFFF_FFFF && imem_req_addr == 32'h0)
                saw_wrap = 1;
            last_req = imem_req_addr;
            last_req_ok = 1;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (mem_due.size() > 0 && due <= mem_due[$])
                due = mem_due[$] + 1;
            mem_due.push_back(due);
            mem_addr.push_back(imem_req_addr);
            mem_ep.push_back(epoch);
            exp_req = exp_req + 32'd1;
            live++;
        end
        took = 0;
        if (id_valid === 1'b1 && id_ready === 1'b1) begin
            checks++;
            if (id_pc !== exp_pc || id_inst !== word_of(exp_pc)) begin
                errors++;
                $display("FAIL id_data: got pc=%h inst=%h required pc=%h inst=%h (cycle %0d)",
                         id_pc, id_inst, exp_pc, word_of(exp_pc), cyc);
            end
            took = 1;
            took_pc = id_pc;
            exp_pc = exp_pc + 32'd1;
            live--;
            consumed++;
        end
        fresh = rsp_now && (rsp_ep == epoch) && !redir;
        if (fresh && !(took && took_pc === rsp_a))
            expect_vis = 1;
        if (redir) begin
            epoch++;
            live = 0;
            exp_pc = rpc_eff;
            exp_req = rpc_eff;
            last_req_ok = 0;
            expect_empty = 1;
        end
        stale = 0;
        foreach (mem_ep[i])
            if (mem_ep[i] != epoch)
                stale++;
        checks++;
        if (live + stale > DEPTH) begin
            errors++;
            $display("FAIL credit: queued+in_flight=%0d required <= %0d (cycle %0d)", live + stale, DEPTH, cyc);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0 ||
            imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_outputs: req_valid=%b id_valid=%b inst=%h pc=%h addr=%h required 0 0 0 0 %h",
                     imem_req_valid, id_valid, id_inst, id_pc, imem_req_addr, RESET_PC);
        end
        rst = 1'b0;
        model_reset();
        cyc = 0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: imem_req_valid=%b required 0", imem_req_valid);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 60 && consumed < 12; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (consumed < 12) begin
            errors++;
            $display("FAIL stream_progress: consumed=%0d required 12", consumed);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        stall_pc = 32'd3;
        stall_hit = 0;
        stall_arm = 1;
        for (int i = 0; i < 40 && !stall_hit; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        stall_arm = 0;
        checks++;
        if (!stall_hit) begin
            errors++;
            $display("FAIL stall_reach: pc 3 never presented");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'd3) begin
                errors++;
                $display("FAIL stall_hold: id_valid=%b id_pc=%h required 1 00000003", id_valid, id_pc);
            end
            step(1'b0, 1'b1, 1'b0, '0);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_credit: imem_req_valid=%b required 0", imem_req_valid);
        end
        for (int i = 0; i < 40 && exp_pc != 32'd6; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (exp_pc !== 32'd6) begin
            errors++;
            $display("FAIL stall_resume: next pc=%h required 00000006", exp_pc);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 40 && !(mem_due.size() == 2 && mem_due[0] != cyc); i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (mem_due.size() != 2) begin
            errors++;
            $display("FAIL redirect_setup: outstanding=%0d required 2", mem_due.size());
        end
        step(1'b1, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 40 && exp_pc != 32'h42; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (exp_pc !== 32'h42) begin
            errors++;
            $display("FAIL redirect_progress: next pc=%h required 00000042", exp_pc);
        end
    endtask

    task automatic test_collide();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        collide_pc = 32'h200;
        collide_seen = 0;
        collide_arm = 1;
        for (int i = 0; i < 400 && !collide_seen; i++)
            step(logic'($urandom_range(1, 0)), 1'b1, 1'b0, '0);
        collide_arm = 0;
        checks++;
        if (!collide_seen) begin
            errors++;
            $display("FAIL collide_reach: no redirect with response and pop in one cycle");
        end
        for (int i = 0; i < 60 && exp_pc != 32'h202; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (exp_pc !== 32'h202) begin
            errors++;
            $display("FAIL collide_progress: next pc=%h required 00000202", exp_pc);
        end
    endtask

    task automatic test_req_toggle();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 40; i++)
            step(1'b1, logic'(i % 2 == 0), 1'b0, '0);
        checks++;
        if (consumed < 8) begin
            errors++;
            $display("FAIL toggle_progress: consumed=%0d required >= 8", consumed);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1;
        lat_max = 1;
        saw_wrap = 0;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 40 && exp_pc != 32'h2; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_addr: request after FFFFFFFF was not 00000000");
        end
        checks++;
        if (exp_pc !== 32'h2) begin
            errors++;
            $display("FAIL wrap_progress: next pc=%h required 00000002", exp_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 40 && mem_due.size() != 2; i++)
            step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (mem_due.size() != 2) begin
            errors++;
            $display("FAIL midreset_setup: outstanding=%0d required 2", mem_due.size());
        end
        imem_req_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0 ||
            imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midreset_outputs: req_valid=%b id_valid=%b inst=%h pc=%h addr=%h required 0 0 0 0 %h",
                     imem_req_valid, id_valid, id_inst, id_pc, imem_req_addr, RESET_PC);
        end
        imem_rsp_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (!last_req_ok || last_req !== RESET_PC) begin
            errors++;
            $display("FAIL midreset_first_req: seen=%0d addr=%h required 1 %h", last_req_ok, last_req, RESET_PC);
        end
        for (int i = 0; i < 40 && exp_pc != 32'd3; i++)
            step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 800; i++)
            step(logic'($urandom_range(99, 0) < 70), logic'($urandom_range(99, 0) < 75),
                 logic'($urandom_range(99, 0) < 4), $urandom);
        checks++;
        if (consumed < 60) begin
            errors++;
            $display("FAIL random_progress: consumed=%0d required >= 60", consumed);
        end
    endtask

    initial begin
        stall_arm = 0;
        collide_arm = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collide();
        test_req_toggle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
